// File: rtl/alu_pkg.sv
// Shared types and helpers for the shared-ALU arbiter: operation codes,
// arbiter FSM states and the datapath width.
package alu_pkg;

    localparam int W = 32;

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_ADD = 3'b010,
        OP_SUB = 3'b110,
        OP_SLT = 3'b111
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // True for the five function codes the ALU implements.
    function automatic logic alu_op_legal(input logic [2:0] f);
        logic legal;
        case (f)
            OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT: legal = 1'b1;
            default:                               legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU shared by all requesters. Unknown function codes
// produce zero; the arbiter flags them separately.
module alu
    import alu_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [2:0]   f,
    output logic [W-1:0] y,
    output logic         zero
);

    // Select the operation result for the current function code.
    always_comb begin
        y = {W{1'b0}};
        case (f)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            OP_SLT:  y = ($signed(a) < $signed(b)) ? {{(W-1){1'b0}}, 1'b1} : {W{1'b0}};
            default: y = {W{1'b0}};
        endcase
    end

    assign zero = (y == {W{1'b0}});

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: searches upward from the requester
// after last_grant, wrapping around, and returns the first one asking.
module rr_arbiter #(
    parameter  int NREQ = 2,
    localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last_grant,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   grant_idx
);

    logic w_found;
    logic w_hit;

    // Walk the requesters in priority order and grant the first active one.
    always_comb begin
        grant     = {NREQ{1'b0}};
        grant_idx = {IW{1'b0}};
        w_found   = 1'b0;
        w_hit     = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            int idx;
            idx        = (int'(last_grant) + i) % NREQ;
            w_hit      = ~w_found & req[idx];
            grant[idx] = w_hit;
            grant_idx  = w_hit ? IW'(idx) : grant_idx;
            w_found    = w_found | w_hit;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between NREQ requesters. A request is accepted in IDLE
// under round-robin, its operands are registered and executed in EXEC, and
// the result is held in RESP until the granted requester takes it.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter  int NREQ = 2,
    parameter  int W    = 32,
    localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    input  logic [NREQ*3-1:0] req_f,
    output logic [NREQ-1:0]   resp_valid,
    input  logic [NREQ-1:0]   resp_ready,
    output logic [W-1:0]      resp_y,
    output logic              resp_zero,
    output logic              resp_err,
    output logic              busy
);

    state_t          r_state;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [2:0]      r_f;
    logic [IW-1:0]   r_g;
    logic [IW-1:0]   r_last;
    logic [W-1:0]    r_y;
    logic            r_zero;
    logic            r_err;
    logic [NREQ-1:0] r_resp_valid;
    logic            r_busy;

    logic [NREQ-1:0] w_grant;
    logic [IW-1:0]   w_grant_idx;
    logic [W-1:0]    w_alu_y;
    logic            w_alu_zero;
    logic            w_legal;
    logic [NREQ-1:0] w_g_onehot;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr (
        .req        (req_valid),
        .last_grant (r_last),
        .grant      (w_grant),
        .grant_idx  (w_grant_idx)
    );

    alu #(
        .W (W)
    ) u_alu (
        .a    (r_a),
        .b    (r_b),
        .f    (r_f),
        .y    (w_alu_y),
        .zero (w_alu_zero)
    );

    assign w_legal    = alu_op_legal(r_f);
    assign w_g_onehot = {{(NREQ-1){1'b0}}, 1'b1} << r_g;

    // Acceptance is only offered while idle; the picker yields zero with no request.
    assign req_ready  = (r_state == IDLE) ? w_grant : {NREQ{1'b0}};

    assign resp_valid = r_resp_valid;
    assign resp_y     = r_y;
    assign resp_zero  = r_zero;
    assign resp_err   = r_err;
    assign busy       = r_busy;

    // Arbiter FSM: accept, execute, then hold the response until taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_a          <= {W{1'b0}};
            r_b          <= {W{1'b0}};
            r_f          <= 3'b000;
            r_g          <= {IW{1'b0}};
            r_last       <= IW'(NREQ - 1);
            r_y          <= {W{1'b0}};
            r_zero       <= 1'b0;
            r_err        <= 1'b0;
            r_resp_valid <= {NREQ{1'b0}};
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (|req_valid) begin
                        r_a     <= req_a[w_grant_idx*W +: W];
                        r_b     <= req_b[w_grant_idx*W +: W];
                        r_f     <= req_f[w_grant_idx*3 +: 3];
                        r_g     <= w_grant_idx;
                        r_state <= EXEC;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                EXEC: begin
                    // Illegal codes discard the ALU output and report an error.
                    r_y          <= w_legal ? w_alu_y : {W{1'b0}};
                    r_zero       <= w_legal ? w_alu_zero : 1'b1;
                    r_err        <= ~w_legal;
                    r_resp_valid <= w_g_onehot;
                    r_state      <= RESP;
                    r_busy       <= 1'b1;
                end
                RESP: begin
                    // Only the granted requester's ready completes the response.
                    if (resp_ready[r_g]) begin
                        r_resp_valid <= {NREQ{1'b0}};
                        r_last       <= r_g;
                        r_state      <= IDLE;
                        r_busy       <= 1'b0;
                    end else begin
                        r_state      <= RESP;
                        r_busy       <= 1'b1;
                    end
                end
                default: begin
                    r_resp_valid <= {NREQ{1'b0}};
                    r_state      <= IDLE;
                    r_busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus random
// traffic, checked every cycle against a transaction-level model.
module tb_alu_arbiter;

    localparam int N = 2;
    localparam int W = 32;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N*3-1:0] req_f;
    logic [N-1:0]   resp_valid;
    logic [N-1:0]   resp_ready;
    logic [W-1:0]   resp_y;
    logic           resp_zero;
    logic           resp_err;
    logic           busy;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Transaction model: at most one outstanding operation, due two cycles after acceptance.
    int         m_last = N - 1;
    bit         m_busy = 1'b0;
    int         m_g    = 0;
    int         m_due  = 0;
    logic [W-1:0] m_y;
    logic       m_zero;
    logic       m_err;
    int         n_resp = 0;
    logic [W-1:0] obs_y;
    logic       obs_zero;
    logic       obs_err;
    int         grant_log[$];

    alu_arbiter #(.NREQ(N), .W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_f      (req_f),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_y     (resp_y),
        .resp_zero  (resp_zero),
        .resp_err   (resp_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] v, input int last);
        for (int i = 1; i <= N; i++) begin
            int idx;
            idx = (last + i) % N;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic ref_alu(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] f,
                           output logic [W-1:0] y, output logic z, output logic e);
        e = 1'b0;
        case (f)
            3'b000:  y = a & b;
            3'b001:  y = a | b;
            3'b010:  y = a + b;
            3'b110:  y = a - b;
            3'b111:  y = (int'($signed(a)) < int'($signed(b))) ? 32'd1 : 32'd0;
            default: begin y = 32'd0; e = 1'b1; end
        endcase
        z = (y == 32'd0);
    endtask

    // One clock cycle: drive inputs, check all outputs at the falling edge, advance the model.
    task automatic cycle(input logic [N-1:0] v, input logic [N*W-1:0] a, input logic [N*W-1:0] b,
                         input logic [N*3-1:0] f, input logic [N-1:0] rr);
        logic [N-1:0] exp_ready;
        logic [N-1:0] exp_rv;
        int g;
        req_valid  = v;
        req_a      = a;
        req_b      = b;
        req_f      = f;
        resp_ready = rr;
        @(negedge clk);
        exp_ready = '0;
        g = -1;
        if (!m_busy) begin
            g = rr_pick(v, m_last);
            if (g >= 0) exp_ready[g] = 1'b1;
        end
        check_eq("req_ready", 64'(req_ready), 64'(exp_ready));
        exp_rv = '0;
        if (m_busy && cyc >= m_due) exp_rv[m_g] = 1'b1;
        check_eq("resp_valid", 64'(resp_valid), 64'(exp_rv));
        check_eq("busy", 64'(busy), 64'(m_busy));
        if (exp_rv != '0) begin
            check_eq("resp_y", 64'(resp_y), 64'(m_y));
            check_eq("resp_zero", 64'(resp_zero), 64'(m_zero));
            check_eq("resp_err", 64'(resp_err), 64'(m_err));
            obs_y    = resp_y;
            obs_zero = resp_zero;
            obs_err  = resp_err;
            if (rr[m_g]) begin
                m_busy = 1'b0;
                m_last = m_g;
                n_resp++;
            end
        end
        if (g >= 0) begin
            m_busy = 1'b1;
            m_g    = g;
            m_due  = cyc + 2;
            grant_log.push_back(g);
            ref_alu(a[g*W +: W], b[g*W +: W], f[g*3 +: 3], m_y, m_zero, m_err);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n, input logic [N-1:0] rr);
        for (int i = 0; i < n; i++) cycle('0, '0, '0, '0, rr);
    endtask

    // Single request from requester r, then enough idle cycles to collect the result.
    task automatic single(input int r, input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] f);
        logic [N*W-1:0] pa;
        logic [N*W-1:0] pb;
        logic [N*3-1:0] pf;
        logic [N-1:0]   v;
        pa = '0; pb = '0; pf = '0; v = '0;
        pa[r*W +: W] = a;
        pb[r*W +: W] = b;
        pf[r*3 +: 3] = f;
        v[r] = 1'b1;
        cycle(v, pa, pb, pf, '1);
        idle(3, '1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_req_ready"}, 64'(req_ready), 64'd0);
        check_eq({tag, "_resp_valid"}, 64'(resp_valid), 64'd0);
        check_eq({tag, "_resp_y"}, 64'(resp_y), 64'd0);
        check_eq({tag, "_resp_zero"}, 64'(resp_zero), 64'd0);
        check_eq({tag, "_resp_err"}, 64'(resp_err), 64'd0);
        check_eq({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    task automatic do_reset(input string tag);
        req_valid  = '0;
        resp_ready = '0;
        rst_n      = 1'b0;
        #1;
        check_reset_outputs(tag);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
        m_last = N - 1;
        m_busy = 1'b0;
    endtask

    initial begin
        int n0;
        int cnt0;
        logic [N*W-1:0] ra;
        logic [N*W-1:0] rb;
        logic [N*3-1:0] rf;

        rst_n      = 1'b0;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        req_f      = '0;
        resp_ready = '0;
        @(negedge clk);
        check_reset_outputs("por");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc++;

        // Single ADD from requester 0.
        single(0, 32'd5, 32'd7, 3'b010);
        check_eq("add_y", 64'(obs_y), 64'd12);
        check_eq("add_zero", 64'(obs_zero), 64'd0);
        check_eq("add_err", 64'(obs_err), 64'd0);

        // SUB to zero, then signed SLT.
        single(0, 32'd9, 32'd9, 3'b110);
        check_eq("sub_y", 64'(obs_y), 64'd0);
        check_eq("sub_zero", 64'(obs_zero), 64'd1);
        single(1, 32'hFFFF_FFFF, 32'd1, 3'b111);
        check_eq("slt_y", 64'(obs_y), 64'd1);

        // Illegal code, then a legal op clears the error flag.
        single(0, 32'd3, 32'd3, 3'b100);
        check_eq("ill_y", 64'(obs_y), 64'd0);
        check_eq("ill_zero", 64'(obs_zero), 64'd1);
        check_eq("ill_err", 64'(obs_err), 64'd1);
        single(1, 32'hF0, 32'h3C, 3'b000);
        check_eq("and_y", 64'(obs_y), 64'h30);
        check_eq("and_err", 64'(obs_err), 64'd0);

        // Response backpressure while the other requester keeps asking.
        cycle(2'b10, {32'd100, 32'd0}, {32'd23, 32'd0}, {3'b010, 3'b000}, 2'b00);
        for (int i = 0; i < 7; i++)
            cycle(2'b11, {32'd1, 32'd2}, {32'd3, 32'd4}, {3'b010, 3'b001}, 2'b01);
        check_eq("bp_y", 64'(obs_y), 64'd123);
        idle(4, '1);

        // Contention: both requesters always valid, responses always taken.
        n0 = n_resp;
        grant_log.delete();
        for (int i = 0; i < 12; i++)
            cycle(2'b11, {$urandom(), $urandom()}, {$urandom(), $urandom()}, {3'b010, 3'b110}, 2'b11);
        cnt0 = 0;
        foreach (grant_log[i]) if (grant_log[i] == 0) cnt0++;
        check_eq("cont_resp", 64'(n_resp - n0), 64'd4);
        check_eq("cont_g0", 64'(cnt0), 64'd2);
        idle(4, '1);

        // Reset during EXEC: requester 1 in flight, last grant was 0.
        single(0, 32'd1, 32'd1, 3'b010);
        cycle(2'b10, {32'd50, 32'd0}, {32'd8, 32'd0}, {3'b110, 3'b000}, 2'b00);
        do_reset("mid");
        req_valid = 2'b11;
        #1;
        check_eq("post_rst_grant", 64'(req_ready), 64'h1);
        cycle(2'b11, {32'd6, 32'd4}, {32'd2, 32'd2}, {3'b010, 3'b001}, 2'b01);
        idle(3, '1);
        check_eq("post_rst_y", 64'(obs_y), 64'd6);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            ra = {$urandom(), $urandom()};
            rb = {$urandom(), $urandom()};
            if ($urandom_range(0, 3) == 0) rb = ra;
            rf = N*3'($urandom());
            cycle(N'($urandom()), ra, rb, rf, N'($urandom()));
        end
        idle(4, '1);
        check_eq("final_idle", 64'(busy), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
